// File: rtl/counter_sched_pkg.sv
// Shared types and default sizing for the interval-counter scheduler.
package counter_sched_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/sched_counter.sv
// Shared interval counter; synchronous clear wins over enable.
module sched_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock0) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler handing one shared interval counter to NUM_REQ requesters.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                     clock0,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic [PtrW-1:0]    rr_ptr_q, owner_q;
  logic [CNT_W-1:0]   len_q;

  logic [PtrW-1:0]    winner, owner_nxt;
  logic [CNT_W-1:0]   len_win, term;
  logic               any_req, owner_req, at_term, cnt_clr, cnt_en;

  // Search upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    logic        found;
    int unsigned idx;
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = PtrW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    len_win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == PtrW'(i)) len_win = len[i*CNT_W +: CNT_W];
    end
  end

  assign any_req   = |req;
  assign owner_req = req[owner_q];
  assign owner_nxt = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // A latched length of zero behaves as a one-cycle interval.
  assign term      = (len_q == '0) ? '0 : len_q - 1'b1;
  assign at_term   = (count == term);
  assign cnt_clr   = (state_q == StIdle) && any_req;
  assign cnt_en    = (state_q == StRun) && owner_req && !at_term;

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      done_q   <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      len_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StRun;
            grant_q <= NUM_REQ'(1) << winner;
            owner_q <= winner;
            len_q   <= len_win;
          end
        end
        StRun: begin
          if (!owner_req) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= owner_nxt;
          end else if (at_term) begin
            state_q  <= StDone;
            grant_q  <= '0;
            done_q   <= NUM_REQ'(1) << owner_q;
            rr_ptr_q <= owner_nxt;
          end
        end
        StDone: state_q <= StIdle;
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

  sched_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock0 (clock0),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (count)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);

endmodule
